// File: rtl/mem_arb.sv
// ============================================================================
// Module   : mem_arb
// Brief    : Multi-channel beat assembler with a locking round-robin output
//            arbiter. Each channel packs BEATS narrow beats into one word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb #(
  parameter  int NCH   = 2,
  parameter  int IN_W  = 4,
  parameter  int BEATS = 2,
  localparam int OUT_W = IN_W * BEATS,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*IN_W-1:0]   in_data,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic [2*NCH-1:0]      coverage
);

  localparam int          CNT_W       = $clog2(BEATS);
  localparam logic [1:0]  c_st_idle   = 2'd0;
  localparam logic [1:0]  c_st_assem  = 2'd1;
  localparam logic [1:0]  c_st_full   = 2'd2;
  localparam logic [CH_W:0] c_nch     = (CH_W + 1)'(NCH);

  logic [NCH-1:0]       w_full;
  logic [NCH*OUT_W-1:0] w_word_flat;
  logic                 w_any;
  logic                 w_hs;
  logic [CH_W-1:0]      w_grant;
  logic [CH_W-1:0]      w_grant_inc;
  logic [CH_W-1:0]      w_search_g;
  logic                 w_found;
  logic [CH_W:0]        w_sum;
  logic [OUT_W-1:0]     w_sel;

  logic                 r_lock;
  logic [CH_W-1:0]      r_lock_ch;
  logic [CH_W-1:0]      r_rr_ptr;

  // ---------------------------------------------------------------- channels
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [OUT_W-1:0] r_word, w_word_nxt;
    logic [IN_W-1:0]  w_beat;
    logic             w_rdy;
    logic             w_accept;
    logic             w_take;

    assign w_beat   = in_data[c*IN_W +: IN_W];
    assign w_accept = in_valid[c] && w_rdy;
    assign w_take   = w_hs && (w_grant == CH_W'(c));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= c_st_idle;
        r_cnt   <= '0;
        r_word  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_word  <= w_word_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_word_nxt  = r_word;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            w_state_nxt            = c_st_assem;
            w_cnt_nxt              = CNT_W'(1);
            w_word_nxt             = '0;
            w_word_nxt[IN_W-1:0]   = w_beat;
          end
        end
        c_st_assem: begin
          if (flush) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
          end else if (w_accept) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_cnt == CNT_W'(k)) w_word_nxt[k*IN_W +: IN_W] = w_beat;
            end
            if (r_cnt == CNT_W'(BEATS - 1)) begin
              w_state_nxt = c_st_full;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        c_st_full: begin
          if (w_take) w_state_nxt = c_st_idle;
        end
        default: begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      w_rdy = (r_state != c_st_full) && !flush;
    end

    assign in_ready[c]                     = w_rdy;
    assign w_full[c]                       = (r_state == c_st_full);
    assign coverage[2*c +: 2]              = r_state;
    assign w_word_flat[c*OUT_W +: OUT_W]   = r_word;
  end

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    w_search_g = '0;
    w_found    = 1'b0;
    w_sum      = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (CH_W + 1)'(i);
      if (w_sum >= c_nch) w_sum = w_sum - c_nch;
      if (!w_found && w_full[w_sum[CH_W-1:0]]) begin
        w_found    = 1'b1;
        w_search_g = w_sum[CH_W-1:0];
      end
    end
  end

  // A presented word stays put until taken, even if a better-placed channel fills.
  assign w_any       = |w_full;
  assign w_grant     = r_lock ? r_lock_ch : w_search_g;
  assign w_hs        = w_any && out_ready;
  assign w_grant_inc = (w_grant == CH_W'(NCH - 1)) ? '0 : w_grant + CH_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
    end else if (w_hs) begin
      r_lock    <= 1'b0;
      r_rr_ptr  <= w_grant_inc;
    end else if (w_any) begin
      r_lock    <= 1'b1;
      r_lock_ch <= w_grant;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_grant == CH_W'(c)) w_sel = w_word_flat[c*OUT_W +: OUT_W];
    end
  end

  assign out_valid = w_any;
  assign out_data  = w_any ? w_sel : '0;
  assign out_ch    = w_grant;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// ============================================================================
// Module   : tb_mem_arb
// Brief    : Directed and random stimulus for mem_arb against a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arb;
  localparam int NCH = 2, IN_W = 4, BEATS = 2, OUT_W = 8, CH_W = 1;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                flush = 1'b0;
  logic [NCH-1:0]      in_valid = '0;
  logic [NCH*IN_W-1:0] in_data = '0;
  logic [NCH-1:0]      in_ready;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [OUT_W-1:0]    out_data;
  logic [CH_W-1:0]     out_ch;
  logic [2*NCH-1:0]    coverage;

  always #5 clock = ~clock;

  mem_arb #(.NCH(NCH), .IN_W(IN_W), .BEATS(BEATS)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .coverage(coverage)
  );

  int total = 0;
  int bad   = 0;

  // Word-level model: beats gathered per channel, one finished word per channel.
  bit               m_done [NCH];
  logic [OUT_W-1:0] m_word [NCH];
  logic [OUT_W-1:0] m_acc  [NCH];
  int               m_cnt  [NCH];
  int               m_ptr;
  bit               m_locked;
  int               m_lock;

  function automatic bit m_any();
    for (int c = 0; c < NCH; c++) if (m_done[c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_grant();
    if (m_locked) return m_lock;
    for (int i = 0; i < NCH; i++) if (m_done[(m_ptr + i) % NCH]) return (m_ptr + i) % NCH;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 0; m_word[c] = '0; m_acc[c] = '0; m_cnt[c] = 0;
    end
    m_ptr = 0; m_locked = 0; m_lock = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0]   rdy;
    logic [2*NCH-1:0] cov;
    bit ov;
    int g;
    ov = m_any();
    g  = m_grant();
    for (int c = 0; c < NCH; c++) begin
      rdy[c]       = !m_done[c] && !flush;
      cov[2*c +: 2] = m_done[c] ? 2'd2 : (m_cnt[c] > 0 ? 2'd1 : 2'd0);
    end
    check("cyc.in_ready", 32'(in_ready), 32'(rdy));
    check("cyc.out_valid", 32'(out_valid), 32'(ov));
    check("cyc.out_data", 32'(out_data), ov ? 32'(m_word[g]) : 32'd0);
    if (ov) check("cyc.out_ch", 32'(out_ch), 32'(g));
    check("cyc.coverage", 32'(coverage), 32'(cov));
  endtask

  task automatic model_update();
    bit ov;
    int g;
    ov = m_any();
    g  = m_grant();
    for (int c = 0; c < NCH; c++) begin
      if (m_done[c]) continue;
      if (flush) begin
        m_cnt[c] = 0; m_acc[c] = '0;
      end else if (in_valid[c]) begin
        m_acc[c] = m_acc[c] | (OUT_W'(in_data[c*IN_W +: IN_W]) << (m_cnt[c] * IN_W));
        m_cnt[c]++;
        if (m_cnt[c] == BEATS) begin
          m_done[c] = 1; m_word[c] = m_acc[c]; m_cnt[c] = 0; m_acc[c] = '0;
        end
      end
    end
    if (ov && out_ready) begin
      m_done[g] = 0; m_locked = 0; m_ptr = (g + 1) % NCH;
    end else if (ov) begin
      m_locked = 1; m_lock = g;
    end
  endtask

  task automatic step();
    @(negedge clock);
    compare_all();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic [IN_W-1:0] d0, input logic [IN_W-1:0] d1);
    in_valid = v;
    in_data  = {d1, d0};
  endtask

  // Reset is applied and released between clock edges.
  task automatic do_reset(input string tag);
    flush   = 1'b0;
    reset_n = 1'b0;
    #2;
    check({tag, ".rst_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rst_out_data"}, 32'(out_data), 32'd0);
    check({tag, ".rst_out_ch"}, 32'(out_ch), 32'd0);
    check({tag, ".rst_coverage"}, 32'(coverage), 32'd0);
    check({tag, ".rst_in_ready"}, 32'(in_ready), 32'h3);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    do_reset("init");

    // single channel assembly, immediate drain
    out_ready = 1'b1;
    drive(2'b01, 4'h3, 4'h0); step();
    check("r024.cov_assem", 32'(coverage[1:0]), 32'd1);
    drive(2'b01, 4'hA, 4'h0); step();
    check("r024.valid", 32'(out_valid), 32'd1);
    check("r024.data", 32'(out_data), 32'hA3);
    check("r024.ch", 32'(out_ch), 32'd0);
    check("r024.cov_full", 32'(coverage[1:0]), 32'd2);
    drive(2'b00, 4'h0, 4'h0); step();
    check("r024.cov_idle", 32'(coverage[1:0]), 32'd0);

    // both channels full, round-robin order
    do_reset("r025");
    out_ready = 1'b0;
    drive(2'b11, 4'h1, 4'h3); step();
    drive(2'b11, 4'h2, 4'h4); step();
    check("r025.first_data", 32'(out_data), 32'h21);
    check("r025.first_ch", 32'(out_ch), 32'd0);
    drive(2'b00, 4'h0, 4'h0); out_ready = 1'b1; step();
    check("r025.second_data", 32'(out_data), 32'h43);
    check("r025.second_ch", 32'(out_ch), 32'd1);
    step();
    drive(2'b11, 4'h5, 4'h7); step();
    drive(2'b11, 4'h6, 4'h8); step();
    check("r025.rep_ch", 32'(out_ch), 32'd0);
    check("r025.rep_data", 32'(out_data), 32'h65);
    drive(2'b00, 4'h0, 4'h0); step();
    check("r025.rep2_data", 32'(out_data), 32'h87);
    step();

    // lock holds ch1 while ch0 fills
    out_ready = 1'b0;
    drive(2'b10, 4'h0, 4'h5); step();
    drive(2'b10, 4'h0, 4'h6); step();
    drive(2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("r026.hold_ch", 32'(out_ch), 32'd1);
      check("r026.hold_data", 32'(out_data), 32'h65);
    end
    drive(2'b01, 4'h7, 4'h0); step();
    drive(2'b01, 4'h8, 4'h0); step();
    check("r026.locked_ch", 32'(out_ch), 32'd1);
    check("r026.locked_data", 32'(out_data), 32'h65);
    drive(2'b00, 4'h0, 4'h0); out_ready = 1'b1; step();
    check("r026.next_ch", 32'(out_ch), 32'd0);
    check("r026.next_data", 32'(out_data), 32'h87);
    step();

    // flush discards ch0 partial, ch1 full untouched
    out_ready = 1'b0;
    drive(2'b11, 4'h5, 4'h1); step();
    drive(2'b10, 4'h0, 4'h2); step();
    flush = 1'b1; drive(2'b11, 4'h9, 4'h9); step();
    flush = 1'b0;
    check("r027.cov_after_flush", 32'(coverage), 32'h8);
    drive(2'b01, 4'h6, 4'h0); step();
    drive(2'b01, 4'h7, 4'h0); step();
    check("r027.ch1_first", 32'(out_data), 32'h21);
    drive(2'b00, 4'h0, 4'h0); out_ready = 1'b1; step();
    check("r027.ch0_data", 32'(out_data), 32'h76);
    check("r027.ch0_ch", 32'(out_ch), 32'd0);
    step();

    // async reset mid-assembly and mid-handshake
    out_ready = 1'b0;
    drive(2'b01, 4'h1, 4'h0); step();
    drive(2'b11, 4'h2, 4'h3); step();
    check("r028.pre_valid", 32'(out_valid), 32'd1);
    do_reset("r028");
    drive(2'b00, 4'h0, 4'h0); out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // back-pressure on a full channel keeps the held beat
    out_ready = 1'b0;
    drive(2'b01, 4'h1, 4'h0); step();
    drive(2'b01, 4'h2, 4'h0); step();
    drive(2'b01, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("r029.ready0", 32'(in_ready[0]), 32'd0);
      check("r029.word", 32'(out_data), 32'h21);
    end
    out_ready = 1'b1; step();
    step();
    drive(2'b01, 4'hE, 4'h0); step();
    check("r029.refill", 32'(out_data), 32'hEF);
    drive(2'b00, 4'h0, 4'h0); step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = NCH'($urandom);
      in_data   = (NCH*IN_W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0; drive(2'b00, 4'h0, 4'h0); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
